serial_full_sub: RTL

//   Bit-serial N-bit subtractor (diff = a - b - borrowIn). One full-subtractor

---
 rtl/serial_full_sub_if.sv | 32 +++
 rtl/serial_full_sub.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serial_full_sub_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_full_sub_if
//  Description : Handshake and operand/result bundle for the bit-serial
//                subtractor. The master issues start with operands; the
//                slave reports busy/done and the held results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_full_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrowIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrowOut;
    logic             overflow;

    modport master (
        output start, a, b, borrowIn,
        input  busy, done, diff, borrowOut, overflow
    );

    modport slave (
        input  start, a, b, borrowIn,
        output busy, done, diff, borrowOut, overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_full_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_full_sub
//  Description : Bit-serial WIDTH-bit subtractor, diff = a - b - borrowIn.
//                One full-subtractor cell plus a borrow flop processes one
//                bit per clock, LSB first. Results are registered and held
//                until the next completed operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_full_sub #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    serial_full_sub_if.slave  bus
);
    localparam int             CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic             w_accept;

    // Full-subtractor cell on the current LSBs; a new request is taken in
    // IDLE and also in DONE so back-to-back operations lose no cycle.
    always_comb begin
        w_x       = r_a_sh[0];
        w_y       = r_b_sh[0];
        w_d       = w_x ^ w_y ^ r_br;
        w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
        w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    end

    // Control FSM, serial datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res        <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_RUN: begin
                    r_res  <= {w_d, r_res[WIDTH-1:1]};
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Overflow uses the captured operand signs; borrowIn
                    // only reaches it through the result MSB.
                    r_done       <= 1'b1;
                    r_diff       <= r_res;
                    r_borrow_out <= r_br;
                    r_overflow   <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Capture overrides the IDLE/DONE next-state above.
            if (w_accept) begin
                r_a_sh  <= bus.a;
                r_b_sh  <= bus.b;
                r_br    <= bus.borrowIn;
                r_a_msb <= bus.a[WIDTH-1];
                r_b_msb <= bus.b[WIDTH-1];
                r_res   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= S_RUN;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.diff      = r_diff;
    assign bus.borrowOut = r_borrow_out;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire
